// File: rtl/register_file_pkg.sv
// Shared constants and types for the register file.
// Default geometry, data word and register address typedefs.
package register_file_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    typedef logic [DATA_W_DEF-1:0] word_t;
    typedef logic [ADDR_W_DEF-1:0] addr_t;

endpackage

// File: rtl/register_file_if.sv
// Write/read bus of the register file.
// Master drives write and read addresses; slave returns read data.
interface register_file_if
    import register_file_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);

    logic              EN;
    logic [ADDR_W-1:0] WA;
    logic [DATA_W-1:0] WD;
    logic [ADDR_W-1:0] ADR1;
    logic [ADDR_W-1:0] ADR2;
    logic [DATA_W-1:0] RS1;
    logic [DATA_W-1:0] RS2;

    modport master (
        output EN, WA, WD, ADR1, ADR2,
        input  RS1, RS2
    );

    modport slave (
        input  EN, WA, WD, ADR1, ADR2,
        output RS1, RS2
    );

endinterface

// File: rtl/register_file.sv
// Two-read, one-write register file with hardwired zero register.
// Reads are combinational; writes land on the rising clock edge.
module register_file
    import register_file_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input logic             CLK,
    input logic             RST_N,
    register_file_if.slave  bus
);

    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];

    // Next state: keep contents, apply one write unless aimed at reg 0.
    always_comb begin
        regs_d = regs_q;
        if (bus.EN && (bus.WA != '0)) begin
            regs_d[bus.WA] = bus.WD;
        end
        regs_d[0] = '0;
    end

    // Storage with asynchronous clear of every register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read muxes: no bypass, reg 0 forced to zero.
    always_comb begin
        bus.RS1 = (bus.ADR1 == '0) ? '0 : regs_q[bus.ADR1];
        bus.RS2 = (bus.ADR2 == '0) ? '0 : regs_q[bus.ADR2];
    end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file.
// Directed scenarios plus random traffic against an array model.
module tb_register_file;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    logic [31:0] model [32];

    register_file_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    register_file #(.DATA_W(32), .ADDR_W(5)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
    endtask

    task automatic drive(input logic en, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [4:0] a1,
                         input logic [4:0] a2);
        bus.EN   = en;
        bus.WA   = wa;
        bus.WD   = wd;
        bus.ADR1 = a1;
        bus.ADR2 = a2;
        #1;
    endtask

    task automatic test_reset();
        logic [4:0] a;
        rst_n = 1'b0;
        drive(1'b1, 5'd9, 32'h1234_5678, 5'd9, 5'd9);
        tick();
        for (int i = 0; i < 32; i += 3) begin
            a = i[4:0];
            drive(1'b1, 5'd9, 32'h1234_5678, a, 5'd9);
            n_cmp++;
            if (bus.RS1 !== 32'd0) begin
                n_err++;
                $display("FAIL reset_rs1 a=%0d got %h want 0", a, bus.RS1);
            end
        end
        n_cmp++;
        if (bus.RS2 !== 32'd0) begin
            n_err++;
            $display("FAIL reset_wr_ignored got %h want 0", bus.RS2);
        end
        drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        rst_n = 1'b1;
        model_clear();
        // first edge after release must accept a write
        drive(1'b1, 5'd2, 32'hA5A5_0001, 5'd2, 5'd2);
        tick();
        model[2] = 32'hA5A5_0001;
        n_cmp++;
        if (bus.RS1 !== model[2]) begin
            n_err++;
            $display("FAIL first_write got %h want %h", bus.RS1, model[2]);
        end
    endtask

    task automatic test_zero_reg();
        drive(1'b1, 5'd0, 32'd25, 5'd0, 5'd0);
        tick();
        n_cmp++;
        if (bus.RS1 !== 32'd0 || bus.RS2 !== 32'd0) begin
            n_err++;
            $display("FAIL zero_reg got %h/%h want 0", bus.RS1, bus.RS2);
        end
    endtask

    task automatic test_sweep();
        logic [4:0]  a;
        logic [31:0] d;
        for (int i = 1; i <= 7; i++) begin
            a = 5'(4 * i);
            d = 32'(20 * i);
            drive(1'b1, a, d, 5'd0, 5'd0);
            tick();
            model[a] = d;
            drive(1'b0, 5'd0, 32'd0, a, a);
            n_cmp++;
            if (bus.RS1 !== d || bus.RS2 !== d) begin
                n_err++;
                $display("FAIL sweep a=%0d got %0d/%0d want %0d",
                         a, bus.RS1, bus.RS2, d);
            end
        end
    endtask

    task automatic test_enable();
        drive(1'b1, 5'd5, 32'd25, 5'd5, 5'd5);
        tick();
        model[5] = 32'd25;
        drive(1'b0, 5'd5, 32'd99, 5'd5, 5'd5);
        tick();
        n_cmp++;
        if (bus.RS1 !== 32'd25) begin
            n_err++;
            $display("FAIL enable got %0d want 25", bus.RS1);
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 5'd31, 32'hDEAD_BEEF, 5'd31, 5'd31);
        tick();
        drive(1'b0, 5'd0, 32'd0, 5'd31, 5'd31);
        n_cmp++;
        if (bus.RS1 !== 32'hDEAD_BEEF) begin
            n_err++;
            $display("FAIL pre_reset got %h want deadbeef", bus.RS1);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.RS1 !== 32'd0 || bus.RS2 !== 32'd0) begin
            n_err++;
            $display("FAIL async_reset got %h want 0", bus.RS1);
        end
        #1;
        rst_n = 1'b1;
        model_clear();
        drive(1'b1, 5'd31, 32'd7, 5'd31, 5'd31);
        tick();
        model[31] = 32'd7;
        n_cmp++;
        if (bus.RS1 !== 32'd7) begin
            n_err++;
            $display("FAIL post_reset_write got %0d want 7", bus.RS1);
        end
        drive(1'b0, 5'd0, 32'd0, 5'd4, 5'd5);
        n_cmp++;
        if (bus.RS1 !== 32'd0 || bus.RS2 !== 32'd0) begin
            n_err++;
            $display("FAIL reset_cleared got %h/%h want 0", bus.RS1, bus.RS2);
        end
    endtask

    task automatic test_same_cycle();
        drive(1'b1, 5'd3, 32'd10, 5'd0, 5'd0);
        tick();
        model[3] = 32'd10;
        drive(1'b1, 5'd3, 32'd11, 5'd3, 5'd0);
        n_cmp++;
        if (bus.RS1 !== 32'd10 || bus.RS2 !== 32'd0) begin
            n_err++;
            $display("FAIL same_pre got %0d/%0d want 10/0", bus.RS1, bus.RS2);
        end
        tick();
        model[3] = 32'd11;
        n_cmp++;
        if (bus.RS1 !== 32'd11 || bus.RS2 !== 32'd0) begin
            n_err++;
            $display("FAIL same_post got %0d/%0d want 11/0", bus.RS1, bus.RS2);
        end
    endtask

    task automatic test_random();
        logic        en;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  a1;
        logic [4:0]  a2;
        for (int k = 0; k < 300; k++) begin
            en = 1'($urandom_range(0, 1));
            wa = 5'($urandom_range(0, 31));
            wd = $urandom;
            a1 = (k % 4 == 0) ? wa : 5'($urandom_range(0, 31));
            a2 = (k % 5 == 0) ? a1 : 5'($urandom_range(0, 31));
            drive(en, wa, wd, a1, a2);
            n_cmp++;
            if (bus.RS1 !== model[a1] || bus.RS2 !== model[a2]) begin
                n_err++;
                $display("FAIL rand_pre k=%0d got %h/%h want %h/%h",
                         k, bus.RS1, bus.RS2, model[a1], model[a2]);
            end
            tick();
            if (en && wa != 5'd0) model[wa] = wd;
            n_cmp++;
            if (bus.RS1 !== model[a1] || bus.RS2 !== model[a2]) begin
                n_err++;
                $display("FAIL rand_post k=%0d got %h/%h want %h/%h",
                         k, bus.RS1, bus.RS2, model[a1], model[a2]);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        model_clear();
        drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        test_reset();
        test_zero_reg();
        test_sweep();
        test_enable();
        test_async_reset();
        test_same_cycle();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
